// File: rtl/adder_subtractor.sv
// adder_subtractor: bit-serial two's-complement adder/subtractor.
// Captures A and B on an accepted start. It then resolves one bit per clock,
// LSB first, through a single full-adder cell. The N-bit result and the
// carry-out are valid after N cycles.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   A, B        in   N-bit operands, sampled on an accepted start
//   addsub      in   0 = A+B, 1 = A-B (sampled on an accepted start)
//   start       in   request, level-sampled while idle
//   sum         out  N-bit result register (partial result during calculation)
//   cout        out  carry-out of the MSB (1 = no borrow when subtracting)
//   done        out  one-cycle pulse when sum/cout are valid
//   calculating out  high while the bit-serial computation is running
module adder_subtractor #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         addsub,
  input  logic         start,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         done,
  output logic         calculating
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  // Bit 0 is the CALC flag and bit 1 is the DONE flag. Both status outputs
  // therefore come straight from state flops.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [IW-1:0] idx_q, idx_d;

  logic bit_a, bit_b, bit_s, bit_c;

  // Single full-adder cell shared by all bit positions.
  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];
  assign bit_s = bit_a ^ bit_b ^ carry_q;
  assign bit_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          // Subtract as A + ~B + 1: invert B here and seed the carry with addsub.
          b_d     = B ^ {N{addsub}};
          carry_d = addsub;
          sum_d   = '0;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[idx_q] = bit_s;
        carry_d      = bit_c;
        idx_d        = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign sum         = sum_q;
  assign cout        = cout_q;
  assign calculating = state_q[0];
  assign done        = state_q[1];

endmodule

// File: tb/tb_adder_subtractor.sv
// tb_adder_subtractor: directed and randomized checks of adder_subtractor
// for N = 8 and N = 1. The expected results come from plain integer arithmetic.
module tb_adder_subtractor;

  logic clk;
  logic rst;

  logic [7:0] a8, b8, sum8;
  logic       op8, start8, cout8, done8, calc8;

  logic [0:0] a1, b1, sum1;
  logic       op1, start1, cout1, done1, calc1;

  int total;
  int bad;

  adder_subtractor #(8) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .A          (a8),
    .B          (b8),
    .addsub     (op8),
    .start      (start8),
    .sum        (sum8),
    .cout       (cout8),
    .done       (done8),
    .calculating(calc8)
  );

  adder_subtractor #(1) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .A          (a1),
    .B          (b1),
    .addsub     (op1),
    .start      (start1),
    .sum        (sum1),
    .cout       (cout1),
    .done       (done1),
    .calculating(calc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {cout, sum} for width w using plain integer arithmetic.
  function automatic logic [8:0] model(input int w, input int a, input int b, input bit sub);
    int mask;
    int s;
    bit c;
    mask = (1 << w) - 1;
    if (sub) begin
      s = (a - b) & mask;
      c = (a >= b);
    end else begin
      s = (a + b) & mask;
      c = ((a + b) > mask);
    end
    return {c, s[7:0]};
  endfunction

  // One N=8 operation. A nonzero repulse drives a second start, with new
  // operands, that many cycles into the calculation.
  task automatic op8_run(input string tag, input int a, input int b, input bit sub,
                         input int repulse);
    logic [8:0] exp;
    int lat;
    int calc_cycles;
    exp    = model(8, a, b, sub);
    a8     = a[7:0];
    b8     = b[7:0];
    op8    = sub;
    start8 = 1'b1;
    tick();
    start8      = 1'b0;
    lat         = 0;
    calc_cycles = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      if (calc8 === 1'b1) calc_cycles++;
      if (repulse != 0 && lat == repulse) begin
        a8     = 8'd170;
        b8     = 8'd15;
        op8    = 1'b1;
        start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      tick();
      lat++;
    end
    start8 = 1'b0;
    check({tag, ".latency"}, lat, 8);
    check({tag, ".calc_cycles"}, calc_cycles, 8);
    check({tag, ".sum"}, sum8, exp[7:0]);
    check({tag, ".cout"}, cout8, exp[8]);
    check({tag, ".calc_at_done"}, calc8, 0);
    tick();
    check({tag, ".done_fall"}, done8, 0);
    check({tag, ".sum_hold"}, sum8, exp[7:0]);
  endtask

  task automatic op1_run(input string tag, input int a, input int b, input bit sub);
    logic [8:0] exp;
    int lat;
    exp    = model(1, a, b, sub);
    a1     = a[0:0];
    b1     = b[0:0];
    op1    = sub;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check({tag, ".calc"}, calc1, 1);
    lat = 0;
    while (done1 !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, lat, 1);
    check({tag, ".sum"}, sum1, exp[0]);
    check({tag, ".cout"}, cout1, exp[8]);
    tick();
    check({tag, ".done_fall"}, done1, 0);
  endtask

  initial begin
    int saw_done;
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    a8     = '0;
    b8     = '0;
    op8    = 1'b0;
    start8 = 1'b0;
    a1     = '0;
    b1     = '0;
    op1    = 1'b0;
    start1 = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) tick();
    check("rst.sum8", sum8, 0);
    check("rst.cout8", cout8, 0);
    check("rst.done8", done8, 0);
    check("rst.calc8", calc8, 0);
    check("rst.sum1", sum1, 0);
    check("rst.calc1", calc1, 0);
    rst = 1'b1;
    tick();

    op8_run("add42_15", 42, 15, 1'b0, 0);
    op8_run("sub2_4", 2, 4, 1'b1, 0);
    op8_run("sub88_22", 88, 22, 1'b1, 0);
    op8_run("sub17_17", 17, 17, 1'b1, 0);
    op8_run("add255_1", 255, 1, 1'b0, 0);
    op8_run("sub80_80", 8'h80, 8'h80, 1'b1, 0);
    op8_run("sub7f_80", 8'h7f, 8'h80, 1'b1, 0);
    op8_run("add127_1", 127, 1, 1'b0, 0);

    // A second start during CALC is ignored, and so are the operand changes.
    op8_run("restart", 85, 51, 1'b0, 3);

    // Partial result is filled LSB first from zero.
    a8     = 8'hff;
    b8     = 8'h00;
    op8    = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("partial.cleared", sum8, 0);
    repeat (3) tick();
    check("partial.3bits", sum8, 8'h07);
    repeat (6) tick();

    // Set cout to 1 so that the reset check below can see it cleared.
    op8_run("add200_100", 200, 100, 1'b0, 0);
    // Reset asserted at cycle 4 of CALC.
    a8     = 8'd99;
    b8     = 8'd77;
    op8    = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    check("midrst.calc_before", calc8, 1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst.sum", sum8, 0);
    check("midrst.cout", cout8, 0);
    check("midrst.done", done8, 0);
    check("midrst.calc", calc8, 0);
    tick();
    tick();
    rst      = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1 || calc8 === 1'b1) saw_done++;
    end
    check("midrst.no_done", saw_done, 0);
    op8_run("after_rst", 24, 64, 1'b0, 0);

    // Randomized operations at N = 8.
    for (int i = 0; i < 20; i++) begin
      op8_run("rand8", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              bit'($urandom_range(0, 1)), 0);
    end

    // N = 1.
    op1_run("n1_sub0_0", 0, 0, 1'b1);
    op1_run("n1_add1_1", 1, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      op1_run("rand1", int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
